// File: rtl/perlane_tx_gearbox.sv
// Per-lane TX gearbox: packs 4x(2-bit header + 64-bit block) beats into a
// shift buffer and drains it as a continuous stream of 64-bit SerDes words.
module perlane_tx_gearbox #(
   parameter int unsigned BUF_W = 640,
   parameter int unsigned OUT_W = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_enable,
   input  logic [255:0]     in_txdata,
   input  logic [7:0]       in_synchdr,
   input  logic             in_txdata_valid,
   output logic             out_idle,
   output logic [OUT_W-1:0] out_serdes_data,
   output logic             out_serdes_valid,
   output logic             out_overflow
);

   localparam int unsigned HDR_W    = 2;
   localparam int unsigned BLK_W    = 64;
   localparam int unsigned NBLK     = 4;
   localparam int unsigned SEG_W    = HDR_W + BLK_W;
   localparam int unsigned BEAT_W   = NBLK * SEG_W;
   localparam int unsigned FILL_W   = $clog2(BUF_W + 1);
   localparam int unsigned IDLE_MAX = BUF_W - 2 * BEAT_W;

   logic [BUF_W-1:0]  buf_q, buf_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [OUT_W-1:0]  data_q, data_d;
   logic              valid_q, valid_d;
   logic              idle_q, idle_d;
   logic              ovf_q, ovf_d;

   logic [BEAT_W-1:0] beat_packed;
   logic              pop;
   logic              push;
   logic [FILL_W-1:0] fill_base;
   logic [BUF_W-1:0]  buf_base;
   logic [BUF_W-1:0]  buf_ins;

   // Transmit order per block: header bit 0, header bit 1, then data LSB first.
   always_comb begin
      beat_packed = '0;
      for (int k = 0; k < int'(NBLK); k++) begin
         beat_packed[k*SEG_W +: HDR_W]         = in_synchdr[k*HDR_W +: HDR_W];
         beat_packed[k*SEG_W + HDR_W +: BLK_W] = in_txdata[k*BLK_W +: BLK_W];
      end
   end

   assign pop       = (fill_q >= FILL_W'(OUT_W));
   assign fill_base = pop ? (fill_q - FILL_W'(OUT_W)) : fill_q;
   assign buf_base  = pop ? (buf_q >> OUT_W) : buf_q;
   assign push      = in_txdata_valid &&
                      (((FILL_W+1)'(fill_base) + (FILL_W+1)'(BEAT_W)) <= (FILL_W+1)'(BUF_W));
   // Bits above the fill are always zero, so OR-ing the new beat in is safe.
   assign buf_ins   = BUF_W'(beat_packed) << fill_base;

   always_comb begin
      buf_d   = buf_q;
      fill_d  = fill_q;
      data_d  = data_q;
      valid_d = 1'b0;
      idle_d  = 1'b0;
      ovf_d   = ovf_q;
      if (in_enable) begin
         valid_d = pop;
         if (pop) begin
            data_d = buf_q[OUT_W-1:0];
         end
         buf_d  = push ? (buf_base | buf_ins) : buf_base;
         fill_d = push ? (fill_base + FILL_W'(BEAT_W)) : fill_base;
         if (in_txdata_valid && !push) begin
            ovf_d = 1'b1;
         end
         idle_d = (fill_d <= FILL_W'(IDLE_MAX));
      end else begin
         buf_d  = '0;
         fill_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q   <= '0;
         fill_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         idle_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         idle_q  <= idle_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_idle         = idle_q;
   assign out_serdes_data  = data_q;
   assign out_serdes_valid = valid_q;
   assign out_overflow     = ovf_q;

`ifdef PCS_SIM
   a_fill_max : assert property (@(posedge clk) disable iff (!reset_n)
      fill_q <= FILL_W'(BUF_W));
   a_fill_byte : assert property (@(posedge clk) disable iff (!reset_n)
      fill_q[2:0] == 3'd0);
   a_valid_src : assert property (@(posedge clk) disable iff (!reset_n)
      valid_q |-> ($past(fill_q) >= FILL_W'(OUT_W)));
`endif

endmodule

// File: tb/tb_perlane_tx_gearbox.sv
// Directed bench for perlane_tx_gearbox: hand-computed vector table plus
// bit-queue reference model for streaming, overflow, flush and reset cases.
module tb_perlane_tx_gearbox;

   localparam int unsigned BUF_W  = 640;
   localparam int unsigned BEAT_W = 264;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_enable;
   logic [255:0] in_txdata;
   logic [7:0]   in_synchdr;
   logic         in_txdata_valid;
   logic         out_idle;
   logic [63:0]  out_serdes_data;
   logic         out_serdes_valid;
   logic         out_overflow;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   bit          mq[$];
   logic        m_idle, m_valid, m_ovf;
   logic [63:0] m_data;
   int unsigned beats_acc, words_out;

   typedef struct {
      logic         en;
      logic         v;
      logic [7:0]   hdr;
      logic [255:0] data;
      logic         e_idle;
      logic         e_valid;
      logic [63:0]  e_data;
      logic         e_ovf;
   } vec_t;

   vec_t tbl[14];

   perlane_tx_gearbox #(.BUF_W(640), .OUT_W(64)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .in_enable        (in_enable),
      .in_txdata        (in_txdata),
      .in_synchdr       (in_synchdr),
      .in_txdata_valid  (in_txdata_valid),
      .out_idle         (out_idle),
      .out_serdes_data  (out_serdes_data),
      .out_serdes_valid (out_serdes_valid),
      .out_overflow     (out_overflow)
   );

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] rand_beat();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_idle  = 1'b0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_data  = '0;
   endtask

   // Reference: serial bit queue, LSB transmitted first.
   task automatic model_step(input logic en, input logic v, input logic [7:0] hdr,
                             input logic [255:0] data);
      if (!en) begin
         mq.delete();
         m_valid = 1'b0;
         m_idle  = 1'b0;
      end else begin
         if (mq.size() >= 64) begin
            for (int i = 0; i < 64; i++) m_data[i] = mq.pop_front();
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         if (v) begin
            if (mq.size() + BEAT_W <= BUF_W) begin
               for (int k = 0; k < 4; k++) begin
                  mq.push_back(hdr[2*k]);
                  mq.push_back(hdr[2*k+1]);
                  for (int b = 0; b < 64; b++) mq.push_back(data[64*k+b]);
               end
               beats_acc++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_idle = (mq.size() <= BUF_W - 2*BEAT_W);
      end
   endtask

   task automatic run_cycle(input logic en, input logic v, input logic [7:0] hdr,
                            input logic [255:0] data, input string tag);
      in_enable       = en;
      in_txdata_valid = v;
      in_synchdr      = hdr;
      in_txdata       = data;
      model_step(en, v, hdr, data);
      @(posedge clk);
      #1;
      check1({tag, "_idle"},  64'(out_idle),         64'(m_idle));
      check1({tag, "_valid"}, 64'(out_serdes_valid), 64'(m_valid));
      check1({tag, "_data"},  out_serdes_data,       m_data);
      check1({tag, "_ovf"},   64'(out_overflow),     64'(m_ovf));
      if (out_serdes_valid) words_out++;
   endtask

   initial begin
      logic [255:0] kd;
      logic [7:0]   kh;
      bit           seen;

      // {en, v, hdr, data, exp idle, exp valid, exp data, exp ovf}
      tbl[0]  = '{1'b1, 1'b0, 8'h00,        '0, 1'b1, 1'b0, 64'h0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 8'b10_01_10_01, '0, 1'b0, 1'b0, 64'h0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 8'h00,        '0, 1'b0, 1'b1, 64'h1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 8'h00,        '0, 1'b0, 1'b1, 64'h8, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 8'h00,        '0, 1'b1, 1'b1, 64'h10, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 8'h00,        '0, 1'b1, 1'b1, 64'h80, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'h00,        '0, 1'b1, 1'b0, 64'h80, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 8'h00,        '0, 1'b0, 1'b0, 64'h80, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 8'h55,        '1, 1'b0, 1'b0, 64'h80, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 8'h00,        '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 8'h00,        '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 8'h00,        '0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFDF, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 8'h00,        '0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF7F, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 8'h00,        '0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF7F, 1'b0};

      reset_n         = 1'b0;
      in_enable       = 1'b1;
      in_txdata_valid = 1'b0;
      in_synchdr      = '0;
      in_txdata       = '0;
      beats_acc       = 0;
      words_out       = 0;
      model_reset();
      #1;
      check1("rst_idle",  64'(out_idle),         64'h0);
      check1("rst_valid", 64'(out_serdes_valid), 64'h0);
      check1("rst_data",  out_serdes_data,       64'h0);
      check1("rst_ovf",   64'(out_overflow),     64'h0);

      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         in_enable       = tbl[i].en;
         in_txdata_valid = tbl[i].v;
         in_synchdr      = tbl[i].hdr;
         in_txdata       = tbl[i].data;
         @(posedge clk);
         #1;
         check1($sformatf("tbl%0d_idle", i),  64'(out_idle),         64'(tbl[i].e_idle));
         check1($sformatf("tbl%0d_valid", i), 64'(out_serdes_valid), 64'(tbl[i].e_valid));
         check1($sformatf("tbl%0d_data", i),  out_serdes_data,       tbl[i].e_data);
         check1($sformatf("tbl%0d_ovf", i),   64'(out_overflow),     64'(tbl[i].e_ovf));
      end

      // Asynchronous reset between edges clears outputs immediately.
      #2;
      reset_n = 1'b0;
      #1;
      check1("async_rst_idle", 64'(out_idle),        64'h0);
      check1("async_rst_data", out_serdes_data,      64'h0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      run_cycle(1'b1, 1'b0, 8'h00, '0, "post_rst");

      // Stream honouring out_idle.
      beats_acc = 0;
      words_out = 0;
      for (int c = 0; c < 300; c++) begin
         run_cycle(1'b1, out_idle, 8'($urandom()), rand_beat(), $sformatf("strm%0d", c));
      end
      check1("strm_no_ovf", 64'(out_overflow), 64'h0);
      check1("strm_bits", 64'(words_out*64 + mq.size()), 64'(beats_acc*BEAT_W));

      // Force valid regardless of idle until a beat is dropped.
      for (int c = 0; c < 8 && !m_ovf; c++) begin
         run_cycle(1'b1, 1'b1, 8'($urandom()), rand_beat(), $sformatf("ovf%0d", c));
      end
      check1("ovf_set", 64'(out_overflow), 64'h1);
      for (int c = 0; c < 12; c++) begin
         run_cycle(1'b1, 1'b0, 8'h00, '0, $sformatf("drain%0d", c));
      end
      check1("ovf_sticky", 64'(out_overflow), 64'h1);

      // Flush with fill=200, input ignored, then restart from a fresh beat.
      run_cycle(1'b0, 1'b0, 8'h00, '0, "fl_a");
      run_cycle(1'b1, 1'b1, 8'($urandom()), rand_beat(), "fl_push");
      run_cycle(1'b1, 1'b0, 8'h00, '0, "fl_200");
      run_cycle(1'b0, 1'b1, 8'hFF, '1, "fl_off");
      kd = rand_beat();
      kd[63:0] = 64'h0123_4567_89AB_CDEF;
      kh = 8'b01_10_11_10;
      run_cycle(1'b1, 1'b1, kh, kd, "rs_push");
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         run_cycle(1'b1, 1'b0, 8'h00, '0, $sformatf("rs%0d", c));
         if (out_serdes_valid && !seen) begin
            seen = 1'b1;
            check1("restart_word0", out_serdes_data, {kd[61:0], kh[1:0]});
         end
      end
      if (!seen) begin
         n_vec++;
         n_bad++;
         $display("FAIL restart_word0: got no valid word want %h", {kd[61:0], kh[1:0]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
